bsg_mem_nr1w_sync_bypass: RTL
=============================

// Module: bsg_mem_nr1w_sync_bypass
// PURPOSE
//  Parametrised N-read / 1-write synchronous RAM for register files and tag arrays.
//  Adds per-port output valids and a selectable read-during-write policy.
//  Adds a per-bit write mask and an optional post-reset clear sweep.
//  Read ports are packed vectors, so callers need no per-port-count variant.
// PARAMETERS
//  width_p                 32  data bits per entry
//  els_p                   64  number of entries
//  read_ports_p             3  number of synchronous read ports (>=1)
//  read_write_same_addr_p   0  same-address read+write policy:
//                              0 = illegal (sim error); 1 = read old data; 2 = forward new data
//  addr_width_lp    `BSG_SAFE_CLOG2(els_p)  derived; do not override
// PORTS
//  clk_i      in   1                     clock, all state on posedge
//  reset_n_i  in   1                     asynchronous, active-low reset
//  ready_o    out  1                     1 = array accepts reads and writes
//  w_v_i      in   1                     write enable
//  w_addr_i   in   addr_width_lp         write address
//  w_data_i   in   width_p               write data
//  w_mask_i   in   width_p               per-bit write mask, 1 = write bit
//  r_v_i      in   read_ports_p          per-port read enable
//  r_addr_i   in   read_ports_p*addr_width_lp  packed read addresses, port k at slice k
//  r_data_o   out  read_ports_p*width_p  packed registered read data
//  r_v_o      out  read_ports_p          r_v_o[k] = r_v_i[k] registered, gated by ready_o
// BEHAVIOUR
//  - Reset (reset_n_i=0, asynchronous): r_data_o=0, r_v_o=0.
//    ready_o=0 with clear compiled in; ready_o=1 without it.
//  - Read latency is 1 cycle.
//    - r_v_i[k]=1 at edge N: r_data_o[k] shows mem[r_addr_i[k]] after edge N; r_v_o[k]=1.
//    - r_v_i[k]=0: r_data_o[k] holds its last value; r_v_o[k]=0.
//  - Write commits at the edge where w_v_i & ready_o.
//    - mem[a] <= (mem[a] & ~w_mask_i) | (w_data_i & w_mask_i).
//    - w_addr_i >= els_p: write dropped; sim $error.
//  - Read-during-write, same address, same edge:
//    - policy 1: port returns the pre-write value.
//    - policy 2: port returns the merged post-write value, mask applied.
//    - policy 0: sim $error; returned data undefined.
//  - Any number of ports may read the same address in one cycle.
//  - Reads with r_addr_i >= els_p return X in sim; no error is raised.
//  - While ready_o=0:
//    - w_v_i and r_v_i are ignored.
//    - r_v_o stays 0 and r_data_o holds its value.
//  - Optional clear FSM, 2 states:
//    - CLEAR (entered on reset): writes 0 to entry cnt_r each cycle, cnt_r 0..els_p-1.
//    - Moves to READY after writing entry els_p-1, so clear takes els_p cycles.
//    - ready_o=1 on the cycle after the last clear write.
//    - READY holds until the next reset.
//    - Reset asserted mid-clear: cnt_r=0; the sweep restarts from entry 0.
// CONFIGURATION
//  BSG_MEM_NR1W_SYNC_BYPASS_CLEAR_EN
//   - Defined: clear FSM and counter are built; contents are all-zero when ready_o rises.
//   - Undefined: no FSM; ready_o is tied to 1 outside reset; contents after reset are undefined (X in sim).
// TESTING
//  1. Clear_EN, els_p=64: release reset.
//     -> ready_o=0 for 64 cycles, then 1.
//     -> reads of addr 0, 31 and 63 return 0.
//  2. Write 0xDEADBEEF to addr 5 (mask all 1s); next cycle ports 0,1,2 all read addr 5.
//     -> one cycle later all r_data_o slices = 0xDEADBEEF and r_v_o = 3'b111.
//  3. Write-mask check: mem[9]=0xFFFFFFFF, then write 0x00000000 with mask 0x0000FF00.
//     -> reading addr 9 returns 0xFFFF00FF.
//  4. Policy 2: mem[7]=0x11; same edge write 0x22 to addr 7 and port 1 read of addr 7.
//     -> r_data_o[1]=0x22; policy 1 -> 0x11.
//  5. Clear_EN: assert reset_n_i=0 at clear cycle 20 for 1 cycle.
//     -> ready_o rises 64 cycles after release.
//     -> a write issued at clear cycle 10 before the reset is not present.
//  6. Port 2 reads addr 3 with r_v_i[2]=1, then r_v_i[2]=0 for 4 cycles while addr 3 is rewritten.
//     -> r_data_o[2] holds the old value; r_v_o[2]=0.

Source files
------------

// File: rtl/bsg_mem_nr1w_sync_bypass.sv
// bsg_mem_nr1w_sync_bypass
//   N-read / 1-write synchronous RAM with registered read data, per-port
//   read valids, a per-bit write mask and a selectable same-address
//   read-during-write policy.
//
//   Optional feature macro: BSG_MEM_NR1W_SYNC_BYPASS_CLEAR_EN
//     defined   : a CLEAR/READY FSM sweeps zeros through every entry after
//                 reset; ready_o rises once the sweep is done.
//     undefined : no FSM; ready_o is always 1 and contents after reset are
//                 undefined.
//
// Ports
//   clk_i      clock, all state on posedge
//   reset_n_i  asynchronous active-low reset
//   ready_o    1 = array accepts reads and writes
//   w_v_i      write enable
//   w_addr_i   write address
//   w_data_i   write data
//   w_mask_i   per-bit write mask, 1 = write bit
//   r_v_i      per-port read enable
//   r_addr_i   packed read addresses, port k at slice k
//   r_data_o   packed registered read data, port k at slice k
//   r_v_o      registered per-port read valid
//
// Parameters
//   width_p, els_p, read_ports_p, read_write_same_addr_p
//   (0 = same-address read+write illegal, 1 = read old, 2 = forward new)

module bsg_mem_nr1w_sync_bypass #(
    parameter  int width_p                = 32,
    parameter  int els_p                  = 64,
    parameter  int read_ports_p           = 3,
    parameter  int read_write_same_addr_p = 0,
    localparam int addr_width_lp          = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                                  clk_i,
    input  logic                                  reset_n_i,
    output logic                                  ready_o,
    input  logic                                  w_v_i,
    input  logic [addr_width_lp-1:0]              w_addr_i,
    input  logic [width_p-1:0]                    w_data_i,
    input  logic [width_p-1:0]                    w_mask_i,
    input  logic [read_ports_p-1:0]               r_v_i,
    input  logic [read_ports_p*addr_width_lp-1:0] r_addr_i,
    output logic [read_ports_p*width_p-1:0]       r_data_o,
    output logic [read_ports_p-1:0]               r_v_o
);

    // One extra bit so els_p itself is representable for range checks.
    localparam logic [addr_width_lp:0] els_lp = (addr_width_lp+1)'(els_p);

    function automatic logic in_range(input logic [addr_width_lp-1:0] addr);
        return ({1'b0, addr} < els_lp);
    endfunction

    logic [width_p-1:0]       mem_r [els_p];

    logic                     clear_v;
    logic [addr_width_lp-1:0] clear_addr;

    logic                     w_commit;
    logic [width_p-1:0]       w_old;
    logic [width_p-1:0]       w_merged;

`ifdef BSG_MEM_NR1W_SYNC_BYPASS_CLEAR_EN

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    localparam logic [addr_width_lp-1:0] last_lp = addr_width_lp'(els_p - 1);

    state_e                   state_r;
    state_e                   state_next;
    logic [addr_width_lp-1:0] cnt_r;
    logic [addr_width_lp-1:0] cnt_next;

    // Reset (even mid-sweep) always restarts the sweep from entry 0.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= CLEAR;
            cnt_r   <= '0;
        end else begin
            state_r <= state_next;
            cnt_r   <= cnt_next;
        end
    end

    // CLEAR writes zero to entry cnt_r each cycle; the cycle that writes
    // the last entry also moves to READY, so the sweep takes els_p cycles.
    always_comb begin
        state_next = state_r;
        cnt_next   = cnt_r;
        clear_v    = 1'b0;
        case (state_r)
            CLEAR: begin
                clear_v = 1'b1;
                if (cnt_r == last_lp) begin
                    state_next = READY;
                end else begin
                    cnt_next = cnt_r + 1'b1;
                end
            end
            READY: begin
                state_next = READY;
            end
            default: begin
                state_next = CLEAR;
            end
        endcase
    end

    assign clear_addr = cnt_r;
    assign ready_o    = (state_r == READY);

`else

    assign clear_v    = 1'b0;
    assign clear_addr = '0;
    assign ready_o    = 1'b1;

`endif

    // Out-of-range writes are dropped rather than wrapping.
    assign w_commit = w_v_i & ready_o & in_range(w_addr_i);

    always_comb begin
        w_old = '0;
        if (in_range(w_addr_i)) begin
            w_old = mem_r[w_addr_i];
        end
    end

    assign w_merged = (w_old & ~w_mask_i) | (w_data_i & w_mask_i);

    // Storage is deliberately not reset; the clear sweep, when built,
    // provides known contents. Clear and user writes never overlap because
    // user writes require ready_o.
    always_ff @(posedge clk_i) begin
        if (clear_v) begin
            mem_r[clear_addr] <= '0;
        end else if (w_commit) begin
            mem_r[w_addr_i] <= w_merged;
        end
    end

    for (genvar k = 0; k < read_ports_p; k++) begin : g_rd
        logic [addr_width_lp-1:0] rd_addr;
        logic [width_p-1:0]       rd_val;
        logic [width_p-1:0]       data_r;
        logic                     v_r;

        assign rd_addr = r_addr_i[k*addr_width_lp +: addr_width_lp];

        // Policy 2 forwards the merged write value on a same-address hit;
        // policies 0 and 1 return the array contents before the write.
        always_comb begin
            rd_val = 'x;
            if (in_range(rd_addr)) begin
                rd_val = mem_r[rd_addr];
            end
            if ((read_write_same_addr_p == 2) && w_commit && (w_addr_i == rd_addr)) begin
                rd_val = w_merged;
            end
        end

        // Data only loads on an accepted read, so it holds otherwise.
        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                data_r <= '0;
                v_r    <= 1'b0;
            end else begin
                v_r <= ready_o & r_v_i[k];
                if (ready_o & r_v_i[k]) begin
                    data_r <= rd_val;
                end
            end
        end

        assign r_data_o[k*width_p +: width_p] = data_r;
        assign r_v_o[k]                       = v_r;

`ifndef SYNTHESIS
        always_ff @(posedge clk_i) begin
            if (reset_n_i && (read_write_same_addr_p == 0) && w_commit && r_v_i[k]) begin
                assert (rd_addr != w_addr_i)
                else $error("bsg_mem_nr1w_sync_bypass: same-address read/write on port %0d", k);
            end
        end
`endif
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (reset_n_i && w_v_i && ready_o) begin
            assert (in_range(w_addr_i))
            else $error("bsg_mem_nr1w_sync_bypass: write address %0d out of range", w_addr_i);
        end
    end
`endif

endmodule
